// File: rtl/nbit_chunked_subtractor.sv
// rtl/nbit_chunked_subtractor.sv - multi-cycle chunked N-bit subtractor with borrow flag
//
// Computes num_one - num_two as num_one + ~num_two + 1, CHUNK bits per clock,
// LSB chunk first, with generate/propagate carry logic inside each chunk.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    request, accepted only in IDLE or DONE
//   num_one  minuend, sampled with an accepted start
//   num_two  subtrahend, sampled with an accepted start
//   busy     high while chunks are being processed
//   done     one-cycle pulse in the cycle after D is loaded
//   D        {borrow, diff}; holds its value between results

module nbit_chunked_subtractor #(
  parameter int BIT_NUMBER = 8,
  parameter int CHUNK      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIT_NUMBER-1:0] num_one,
  input  logic [BIT_NUMBER-1:0] num_two,
  output logic                  busy,
  output logic                  done,
  output logic [BIT_NUMBER:0]   D
);

  localparam int K     = BIT_NUMBER / CHUNK;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [BIT_NUMBER-1:0] a_sr;
  logic [BIT_NUMBER-1:0] b_sr;
  logic [BIT_NUMBER-1:0] res_sr;
  logic [BIT_NUMBER-1:0] res_next;
  logic                  carry;
  logic [CNT_W-1:0]      cnt;

  logic [CHUNK-1:0]      sum;
  logic [CHUNK:0]        c;
  logic                  last;
  logic                  accept;

  // Carry chain across the low chunk of the operand shift registers.
  always_comb begin
    logic g;
    logic p;
    g    = 1'b0;
    p    = 1'b0;
    sum  = '0;
    c    = '0;
    c[0] = carry;
    for (int i = 0; i < CHUNK; i++) begin
      g        = a_sr[i] & b_sr[i];
      p        = a_sr[i] ^ b_sr[i];
      sum[i]   = p ^ c[i];
      c[i+1]   = g | (p & c[i]);
    end
  end

  // New sum bits enter from the MSB side; after K chunks the first chunk
  // has walked down to bit 0. The cast keeps the upper BIT_NUMBER bits.
  assign res_next = BIT_NUMBER'({sum, res_sr} >> CHUNK);

  assign last   = (cnt == CNT_W'(K - 1));
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_BUSY;
      S_BUSY:  if (last) state_next = S_DONE;
      S_DONE:  state_next = start ? S_BUSY : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      D      <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_sr  <= num_one;
        b_sr  <= ~num_two;
        carry <= 1'b1;
        cnt   <= '0;
      end else if (state == S_BUSY) begin
        a_sr   <= a_sr >> CHUNK;
        b_sr   <= b_sr >> CHUNK;
        res_sr <= res_next;
        carry  <= c[CHUNK];
        cnt    <= cnt + CNT_W'(1);
        // No carry out of num_one + ~num_two + 1 means num_one < num_two.
        if (last) D <= {~c[CHUNK], res_next};
      end
    end
  end

  assign busy = (state == S_BUSY);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_nbit_chunked_subtractor.sv
// tb/tb_nbit_chunked_subtractor.sv - self-checking bench for nbit_chunked_subtractor

module tb_nbit_chunked_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_v [3];
  logic [7:0] a_v     [3];
  logic [7:0] b_v     [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic [8:0] d_v     [3];

  int tests = 0;
  int fails = 0;
  int cur   = 0;
  logic [8:0] exp_q [$];

  always #5 clk = ~clk;

  nbit_chunked_subtractor #(.BIT_NUMBER(8), .CHUNK(2)) dut_c2 (
    .clk(clk), .rst(rst), .start(start_v[0]), .num_one(a_v[0]), .num_two(b_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .D(d_v[0]));
  nbit_chunked_subtractor #(.BIT_NUMBER(8), .CHUNK(8)) dut_c8 (
    .clk(clk), .rst(rst), .start(start_v[1]), .num_one(a_v[1]), .num_two(b_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .D(d_v[1]));
  nbit_chunked_subtractor #(.BIT_NUMBER(8), .CHUNK(1)) dut_c1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .num_one(a_v[2]), .num_two(b_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .D(d_v[2]));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] exp;
  } vec_t;

  function automatic int kval(input int idx);
    case (idx)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (inst %0d): got %h expected %h", name, cur, act, exp);
    end
  endtask

  task automatic drive(input int idx, input logic s, input logic [7:0] a, input logic [7:0] b);
    for (int j = 0; j < 3; j++) begin
      start_v[j] = 1'b0;
      a_v[j]     = 8'd0;
      b_v[j]     = 8'd0;
    end
    start_v[idx] = s;
    a_v[idx]     = a;
    b_v[idx]     = b;
  endtask

  // Scoreboard: every done pops the oldest expected result.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_v[i] === 1'b1) begin
        if (i != cur || exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: inst %0d D=%h expected no done", i, d_v[i]);
        end else begin
          check("D", d_v[i], exp_q.pop_front());
        end
      end
    end
  end

  // Starts an operation in the current cycle and follows it to its DONE
  // cycle, checking busy/done each cycle. Returns at the negedge of the
  // DONE cycle so a caller can chain a back-to-back start. A nonzero poke
  // pulses start with 7-7 in that BUSY cycle, which must be ignored.
  task automatic do_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                       input logic [8:0] exp, input int poke);
    int k;
    k   = kval(idx);
    cur = idx;
    exp_q.push_back(exp);
    drive(idx, 1'b1, a, b);
    @(posedge clk); #1;
    for (int c = 1; c <= k + 1; c++) begin
      if (c == poke) drive(idx, 1'b1, 8'd7, 8'd7);
      else           drive(idx, 1'b0, 8'd0, 8'd0);
      @(negedge clk);
      check("busy", {8'd0, busy_v[idx]}, {8'd0, (c <= k)});
      check("done", {8'd0, done_v[idx]}, {8'd0, (c == k + 1)});
      if (c <= k) begin
        @(posedge clk); #1;
      end
    end
  endtask

  vec_t tbl [6];

  initial begin
    logic [7:0] ra, rb;
    logic [8:0] re;
    int         rc;

    tbl[0] = '{8'd200, 8'd55,  9'h091};
    tbl[1] = '{8'd5,   8'd9,   9'h1FC};
    tbl[2] = '{8'd0,   8'd255, 9'h101};
    tbl[3] = '{8'd0,   8'd0,   9'h000};
    tbl[4] = '{8'd255, 8'd0,   9'h0FF};
    tbl[5] = '{8'd128, 8'd129, 9'h1FF};

    drive(0, 1'b0, 8'd0, 8'd0);
    rst = 1'b1;
    // start during reset must be ignored
    start_v[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    drive(0, 1'b0, 8'd0, 8'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cur = i;
      check("reset_busy", {8'd0, busy_v[i]}, 9'd0);
      check("reset_done", {8'd0, done_v[i]}, 9'd0);
      check("reset_D", d_v[i], 9'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // start in the first cycle after reset deassertion
    for (int idx = 0; idx < 3; idx++) begin
      for (int t = 0; t < 6; t++) begin
        do_op(idx, tbl[t].a, tbl[t].b, tbl[t].exp, 0);
        @(posedge clk); #1;
      end
    end

    for (int idx = 0; idx < 3; idx++) begin
      // back-to-back: second start in the DONE cycle
      do_op(idx, 8'd200, 8'd55, 9'h091, 0);
      do_op(idx, 8'd3, 8'd4, 9'h1FF, 0);
      @(posedge clk); #1;
      // start while busy is ignored (K=1 has only one busy cycle)
      if (kval(idx) >= 2) begin
        do_op(idx, 8'd100, 8'd1, 9'h063, 2);
        @(posedge clk); #1;
        check("D_hold", d_v[idx], 9'h063);
      end
    end

    // reset mid-operation, after D holds a nonzero result
    for (int idx = 0; idx < 3; idx++) begin
      do_op(idx, 8'd5, 8'd9, 9'h1FC, 0);
      @(posedge clk); #1;
      rc = (kval(idx) >= 3) ? 3 : 1;
      drive(idx, 1'b1, 8'd200, 8'd55);
      @(posedge clk); #1;
      drive(idx, 1'b0, 8'd0, 8'd0);
      for (int c = 1; c < rc; c++) begin
        @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", {8'd0, busy_v[idx]}, 9'd0);
      check("rst_D", d_v[idx], 9'd0);
      for (int c = 0; c < 12; c++) begin
        check("rst_no_done", {8'd0, done_v[idx]}, 9'd0);
        @(negedge clk);
      end
      @(posedge clk); #1;
    end

    // random operands against a reference model
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      re = {(ra < rb), 8'(ra - rb)};
      do_op(n % 3, ra, rb, re, 0);
      @(posedge clk); #1;
    end

    repeat (2) @(negedge clk);
    check("queue_empty", 9'(exp_q.size()), 9'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
